// File: rtl/vram_dp_be.sv
// True dual-port video RAM with per-byte write enables, registered reads and
// a zeroing sweep after reset.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_CLEAR | sweep writes zero to every word; port requests ignored
//   S_READY | normal dual-port read/write operation
module vram_dp_be #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 14,
   parameter int RDW_NEW        = 0,
   parameter int PRIO_A         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                clock,
   input  logic                reset_n,
   output logic                init_busy,
   output logic                collision,
   input  logic                wren_a,
   input  logic                rden_a,
   input  logic [DATA_W/8-1:0] byteena_a,
   input  logic [ADDR_W-1:0]   address_a,
   input  logic [DATA_W-1:0]   data_a,
   output logic [DATA_W-1:0]   q_a,
   output logic                qvalid_a,
   input  logic                wren_b,
   input  logic                rden_b,
   input  logic [DATA_W/8-1:0] byteena_b,
   input  logic [ADDR_W-1:0]   address_b,
   input  logic [DATA_W-1:0]   data_b,
   output logic [DATA_W-1:0]   q_b,
   output logic                qvalid_b
);
   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_clr_cnt;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_q_a;
   logic [DATA_W-1:0]   r_q_b;
   logic                r_qvalid_a;
   logic                r_qvalid_b;
   logic                r_collision;

   logic                w_ready;
   logic                w_hit;
   logic [DATA_W-1:0]   w_old_a;
   logic [DATA_W-1:0]   w_old_b;
   logic [DATA_W-1:0]   w_fin_a;
   logic [DATA_W-1:0]   w_fin_b;

   function automatic logic [DATA_W-1:0] f_merge(
      input logic [DATA_W-1:0] old_word,
      input logic              en,
      input logic [NB-1:0]     be,
      input logic [DATA_W-1:0] wdata
   );
      logic [DATA_W-1:0] res;
      res = old_word;
      for (int i = 0; i < NB; i++) begin
         if (en && be[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      init_busy   = 1'b0;
      case (r_state)
         S_CLEAR: begin
            init_busy = 1'b1;
            if (r_clr_cnt == {ADDR_W{1'b1}}) w_state_nxt = S_READY;
         end
         default: w_state_nxt = S_READY;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)               r_clr_cnt <= '0;
      else if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
   end

   assign w_ready = (r_state == S_READY);
   assign w_hit   = (address_a == address_b);
   assign w_old_a = r_mem[address_a];
   assign w_old_b = r_mem[address_b];

   // Final word at each port's address: the losing port's bytes go in first,
   // the winner's bytes overwrite them where the enables overlap.
   always_comb begin
      w_fin_a = w_old_a;
      w_fin_b = w_old_b;
      if (PRIO_A != 0) begin
         w_fin_a = f_merge(f_merge(w_old_a, wren_b && w_hit, byteena_b, data_b),
                           wren_a, byteena_a, data_a);
         w_fin_b = f_merge(f_merge(w_old_b, wren_b, byteena_b, data_b),
                           wren_a && w_hit, byteena_a, data_a);
      end else begin
         w_fin_a = f_merge(f_merge(w_old_a, wren_a, byteena_a, data_a),
                           wren_b && w_hit, byteena_b, data_b);
         w_fin_b = f_merge(f_merge(w_old_b, wren_a && w_hit, byteena_a, data_a),
                           wren_b, byteena_b, data_b);
      end
   end

   // Storage has no reset; the sweep provides the zeroed contents.
   always_ff @(posedge clock) begin
      if (r_state == S_CLEAR) begin
         r_mem[r_clr_cnt] <= '0;
      end else begin
         if (wren_a)                      r_mem[address_a] <= w_fin_a;
         if (wren_b && !(wren_a && w_hit)) r_mem[address_b] <= w_fin_b;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_q_a       <= '0;
         r_q_b       <= '0;
         r_qvalid_a  <= 1'b0;
         r_qvalid_b  <= 1'b0;
         r_collision <= 1'b0;
      end else if (w_ready) begin
         r_qvalid_a  <= rden_a;
         r_qvalid_b  <= rden_b;
         r_collision <= wren_a && wren_b && w_hit;
         if (rden_a) r_q_a <= (RDW_NEW != 0) ? w_fin_a : w_old_a;
         if (rden_b) r_q_b <= (RDW_NEW != 0) ? w_fin_b : w_old_b;
      end
   end

   assign q_a       = r_q_a;
   assign q_b       = r_q_b;
   assign qvalid_a  = r_qvalid_a;
   assign qvalid_b  = r_qvalid_b;
   assign collision = r_collision;

endmodule

// File: tb/tb_vram_dp_be.sv
// Bench for vram_dp_be: a default instance and an instance with new-data RDW,
// port-B priority and no clear sweep, both checked against a word-level model.
module tb_vram_dp_be;
   localparam int DEPTH = 16384;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        a_wr, a_rd, b_wr, b_rd;
   logic [3:0]  a_be, b_be;
   logic [13:0] a_ad, b_ad;
   logic [31:0] a_d, b_d;

   logic        busy_o [2];
   logic        col_o  [2];
   logic [31:0] q_o    [2][2];
   logic        qv_o   [2][2];

   always #5 clock = ~clock;

   vram_dp_be u_d0 (
      .clock(clock), .reset_n(reset_n), .init_busy(busy_o[0]), .collision(col_o[0]),
      .wren_a(a_wr), .rden_a(a_rd), .byteena_a(a_be), .address_a(a_ad), .data_a(a_d),
      .q_a(q_o[0][0]), .qvalid_a(qv_o[0][0]),
      .wren_b(b_wr), .rden_b(b_rd), .byteena_b(b_be), .address_b(b_ad), .data_b(b_d),
      .q_b(q_o[0][1]), .qvalid_b(qv_o[0][1]));

   vram_dp_be #(.RDW_NEW(1), .PRIO_A(0), .CLEAR_ON_RESET(0)) u_d1 (
      .clock(clock), .reset_n(reset_n), .init_busy(busy_o[1]), .collision(col_o[1]),
      .wren_a(a_wr), .rden_a(a_rd), .byteena_a(a_be), .address_a(a_ad), .data_a(a_d),
      .q_a(q_o[1][0]), .qvalid_a(qv_o[1][0]),
      .wren_b(b_wr), .rden_b(b_rd), .byteena_b(b_be), .address_b(b_ad), .data_b(b_d),
      .q_b(q_o[1][1]), .qvalid_b(qv_o[1][1]));

   // Reference model: one word array per instance, plus a "known" flag for the
   // instance whose memory is never cleared.
   bit          rdw_p [2] = '{1'b0, 1'b1};
   bit          pa_p  [2] = '{1'b1, 1'b0};
   bit          cor_p [2] = '{1'b1, 1'b0};
   logic [31:0] mm  [2][DEPTH];
   bit          kn  [2][DEPTH];
   int          clr_left [2];
   logic [31:0] eq  [2][2];
   bit          eqk [2][2];
   bit          eqv [2][2];
   bit          ecol [2];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         clr_left[k] = cor_p[k] ? DEPTH : 0;
         if (cor_p[k]) begin
            for (int j = 0; j < DEPTH; j++) begin
               mm[k][j] = '0;
               kn[k][j] = 1'b1;
            end
         end
         ecol[k] = 1'b0;
         for (int p = 0; p < 2; p++) begin
            eq[k][p] = '0; eqk[k][p] = 1'b1; eqv[k][p] = 1'b0;
         end
      end
   endtask

   task automatic apply_wr(input int k, input logic [13:0] ad, input logic [3:0] be,
                           input logic [31:0] d);
      for (int i = 0; i < 4; i++) if (be[i]) mm[k][ad][8*i +: 8] = d[8*i +: 8];
      if (be == 4'hF) kn[k][ad] = 1'b1;
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         logic [31:0] oa, ob;
         bit          koa, kob;
         if (clr_left[k] > 0) begin
            clr_left[k]--;
            eqv[k][0] = 1'b0; eqv[k][1] = 1'b0; ecol[k] = 1'b0;
         end else begin
            oa = mm[k][a_ad]; koa = kn[k][a_ad];
            ob = mm[k][b_ad]; kob = kn[k][b_ad];
            ecol[k] = a_wr && b_wr && (a_ad == b_ad);
            if (pa_p[k]) begin
               if (b_wr) apply_wr(k, b_ad, b_be, b_d);
               if (a_wr) apply_wr(k, a_ad, a_be, a_d);
            end else begin
               if (a_wr) apply_wr(k, a_ad, a_be, a_d);
               if (b_wr) apply_wr(k, b_ad, b_be, b_d);
            end
            if (a_rd) begin
               eq[k][0]  = rdw_p[k] ? mm[k][a_ad] : oa;
               eqk[k][0] = rdw_p[k] ? kn[k][a_ad] : koa;
            end
            if (b_rd) begin
               eq[k][1]  = rdw_p[k] ? mm[k][b_ad] : ob;
               eqk[k][1] = rdw_p[k] ? kn[k][b_ad] : kob;
            end
            eqv[k][0] = a_rd; eqv[k][1] = b_rd;
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(clr_left[k] > 0));
         chk($sformatf("col%0d", k), 32'(col_o[k]), 32'(ecol[k]));
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("qv%0d_%0d", k, p), 32'(qv_o[k][p]), 32'(eqv[k][p]));
            if (eqk[k][p]) chk($sformatf("q%0d_%0d", k, p), q_o[k][p], eq[k][p]);
         end
      end
   endtask

   task automatic idle();
      a_wr = 0; a_rd = 0; a_be = '0; a_ad = '0; a_d = '0;
      b_wr = 0; b_rd = 0; b_be = '0; b_ad = '0; b_d = '0;
   endtask

   task automatic rand_req();
      a_wr = 1'($urandom); a_rd = 1'($urandom); a_be = 4'($urandom);
      a_ad = 14'h60 + 14'($urandom_range(0, 7)); a_d = $urandom;
      b_wr = 1'($urandom); b_rd = 1'($urandom); b_be = 4'($urandom);
      b_ad = 14'h60 + 14'($urandom_range(0, 7)); b_d = $urandom;
   endtask

   task automatic cycle();
      @(posedge clock);
      if (reset_n) model_step();
      #1;
      check_all();
   endtask

   task automatic async_reset();
      #2 reset_n = 1'b0;
      #1 model_reset();
      check_all();
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 2; p++) chk("rst_q_imm", q_o[k][p], 32'h0);
      @(negedge clock) reset_n = 1'b1;
   endtask

   typedef struct {
      logic        wa, ra; logic [3:0] bea; logic [13:0] aa; logic [31:0] da;
      logic        wb, rb; logic [3:0] beb; logic [13:0] ab; logic [31:0] db;
      logic        col, qva, qvb;
      logic [31:0] qa0, qa1, qb0, qb1;
   } vec_t;

   vec_t        tbl [14];
   logic [13:0] rd_addrs [7];
   int          n;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{1'b1,1'b0,4'hF,14'h10,32'hAABBCCDD, 1'b0,1'b0,4'h0,14'h0,32'h0,
                  1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0};
      tbl[1]  = '{1'b1,1'b0,4'h5,14'h10,32'h11223344, 1'b0,1'b0,4'h0,14'h0,32'h0,
                  1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0};
      tbl[2]  = '{1'b0,1'b0,4'h0,14'h0,32'h0, 1'b0,1'b1,4'h0,14'h10,32'h0,
                  1'b0,1'b0,1'b1, 32'h0,32'h0,32'hAA22CC44,32'hAA22CC44};
      tbl[3]  = '{1'b0,1'b0,4'h0,14'h0,32'h0, 1'b0,1'b0,4'h0,14'h0,32'h0,
                  1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0};
      tbl[4]  = '{1'b1,1'b0,4'hF,14'h5,32'hDEADBEEF, 1'b0,1'b0,4'h0,14'h0,32'h0,
                  1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0};
      tbl[5]  = '{1'b1,1'b0,4'hF,14'h5,32'h12345678, 1'b0,1'b1,4'h0,14'h5,32'h0,
                  1'b0,1'b0,1'b1, 32'h0,32'h0,32'hDEADBEEF,32'h12345678};
      tbl[6]  = '{1'b1,1'b0,4'hF,14'h20,32'h0, 1'b0,1'b0,4'h0,14'h0,32'h0,
                  1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0};
      tbl[7]  = '{1'b1,1'b0,4'h3,14'h20,32'hAAAAAAAA, 1'b1,1'b0,4'h6,14'h20,32'hBBBBBBBB,
                  1'b1,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0};
      tbl[8]  = '{1'b0,1'b0,4'h0,14'h0,32'h0, 1'b0,1'b0,4'h0,14'h0,32'h0,
                  1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0};
      tbl[9]  = '{1'b0,1'b1,4'h0,14'h20,32'h0, 1'b0,1'b0,4'h0,14'h0,32'h0,
                  1'b0,1'b1,1'b0, 32'h00BBAAAA,32'h00BBBBAA,32'h0,32'h0};
      tbl[10] = '{1'b1,1'b0,4'hF,14'h40,32'h01020304, 1'b0,1'b0,4'h0,14'h0,32'h0,
                  1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0};
      tbl[11] = '{1'b1,1'b1,4'h0,14'h40,32'hFFFFFFFF, 1'b0,1'b0,4'h0,14'h0,32'h0,
                  1'b0,1'b1,1'b0, 32'h01020304,32'h01020304,32'h0,32'h0};
      tbl[12] = '{1'b1,1'b0,4'hF,14'h50,32'h11111111, 1'b1,1'b0,4'hF,14'h51,32'h22222222,
                  1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0,32'h0};
      tbl[13] = '{1'b0,1'b1,4'h0,14'h51,32'h0, 1'b0,1'b1,4'h0,14'h50,32'h0,
                  1'b0,1'b1,1'b1, 32'h22222222,32'h22222222,32'h11111111,32'h11111111};
      rd_addrs = '{14'h0000, 14'h1234, 14'h3FFF, 14'h0010, 14'h0005, 14'h0020, 14'h0060};

      idle();
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1 check_all();
      @(negedge clock) reset_n = 1'b1;

      // First sweep; the no-clear instance takes a write on the very first edge.
      n = 0;
      while (busy_o[0] && n < 20000) begin
         idle();
         if (n == 0) begin a_wr = 1; a_be = 4'hF; a_ad = 14'h3FFF; a_d = 32'hCAFEF00D; end
         if (n == 1) begin a_rd = 1; a_ad = 14'h3FFF; end
         cycle();
         if (n == 1) chk("first_edge_wr", q_o[1][0], 32'hCAFEF00D);
         n++;
      end
      chk("sweep_len", n, DEPTH);

      for (int i = 0; i < 3; i++) begin
         idle(); a_rd = 1; b_rd = 1; a_ad = rd_addrs[i]; b_ad = rd_addrs[i];
         cycle();
         chk("clr_rd_a", q_o[0][0], 32'h0);
         chk("clr_rd_b", q_o[0][1], 32'h0);
         chk("clr_qv_a", 32'(qv_o[0][0]), 32'h1);
         idle(); cycle();
         chk("clr_qv_drop", 32'(qv_o[0][1]), 32'h0);
      end

      for (int i = 0; i < 14; i++) begin
         a_wr = tbl[i].wa; a_rd = tbl[i].ra; a_be = tbl[i].bea; a_ad = tbl[i].aa; a_d = tbl[i].da;
         b_wr = tbl[i].wb; b_rd = tbl[i].rb; b_be = tbl[i].beb; b_ad = tbl[i].ab; b_d = tbl[i].db;
         cycle();
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("tbl%0d_col%0d", i, k), 32'(col_o[k]), 32'(tbl[i].col));
            chk($sformatf("tbl%0d_qva%0d", i, k), 32'(qv_o[k][0]), 32'(tbl[i].qva));
            chk($sformatf("tbl%0d_qvb%0d", i, k), 32'(qv_o[k][1]), 32'(tbl[i].qvb));
            if (tbl[i].qva) chk($sformatf("tbl%0d_qa%0d", i, k), q_o[k][0],
                                (k == 0) ? tbl[i].qa0 : tbl[i].qa1);
            if (tbl[i].qvb) chk($sformatf("tbl%0d_qb%0d", i, k), q_o[k][1],
                                (k == 0) ? tbl[i].qb0 : tbl[i].qb1);
         end
      end

      for (int i = 0; i < 8; i++) begin
         idle(); a_wr = 1; a_be = 4'hF; a_ad = 14'h60 + 14'(i); a_d = '0;
         cycle();
      end
      for (int i = 0; i < 400; i++) begin
         rand_req();
         cycle();
      end

      // Reset while operating with non-zero read data held on the outputs.
      idle(); a_rd = 1; b_rd = 1; a_ad = 14'h10; b_ad = 14'h10;
      cycle();
      chk("pre_rst_q", q_o[0][0], 32'hAA22CC44);
      async_reset();

      n = 0;
      while (n < 8000) begin
         rand_req();
         cycle();
         n++;
      end
      async_reset();

      n = 0;
      while (busy_o[0] && n < 20000) begin
         rand_req();
         cycle();
         n++;
      end
      chk("resweep_len", n, DEPTH);

      for (int i = 0; i < 7; i++) begin
         idle(); a_rd = 1; b_rd = 1; a_ad = rd_addrs[i]; b_ad = rd_addrs[(i + 3) % 7];
         cycle();
         chk("post_sweep_a", q_o[0][0], 32'h0);
         chk("post_sweep_b", q_o[0][1], 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
